// File: rtl/cr_ifu_ibuf_inst_align_if.sv
// Bus between the ibuf entry array / decoder and the instruction aligner.
// align_stall_cnt exists only when CR_IFU_ALIGN_STALL_CNT_EN is defined.
interface cr_ifu_ibuf_inst_align_if #(
    parameter int unsigned ENTRY_NUM = 8
);
    logic                      ibuf_flush;
    logic [ENTRY_NUM-1:0]      entry_vld;
    logic [17*ENTRY_NUM-1:0]   entry_inst;
    logic [ENTRY_NUM-1:0]      entry_acc_err;
    logic                      dec_ready;
    logic [ENTRY_NUM-1:0]      entry_retire0_en;
    logic [ENTRY_NUM-1:0]      entry_retire1_en;
    logic                      align_inst_vld;
    logic [31:0]               align_inst;
    logic                      align_inst_32;
    logic                      align_acc_err;
`ifdef CR_IFU_ALIGN_STALL_CNT_EN
    logic [15:0]               align_stall_cnt;
`endif

    // Entry array and decoder side.
    modport master (
        output ibuf_flush, entry_vld, entry_inst, entry_acc_err, dec_ready,
        input  entry_retire0_en, entry_retire1_en,
               align_inst_vld, align_inst, align_inst_32, align_acc_err
`ifdef CR_IFU_ALIGN_STALL_CNT_EN
        , input align_stall_cnt
`endif
    );

    // Aligner side.
    modport slave (
        input  ibuf_flush, entry_vld, entry_inst, entry_acc_err, dec_ready,
        output entry_retire0_en, entry_retire1_en,
               align_inst_vld, align_inst, align_inst_32, align_acc_err
`ifdef CR_IFU_ALIGN_STALL_CNT_EN
        , output align_stall_cnt
`endif
    );
endinterface

// File: rtl/cr_ifu_ibuf_inst_align.sv
// IFU ibuf read side: assembles 16/32-bit instructions from halfword entries into one output register.
// Optional stall counter enabled by CR_IFU_ALIGN_STALL_CNT_EN.
module cr_ifu_ibuf_inst_align #(
    parameter int unsigned ENTRY_NUM = 8,
    parameter int unsigned PTR_W     = $clog2(ENTRY_NUM)
) (
    input  logic                           cpuclk,
    input  logic                           cpurst_b,
    cr_ifu_ibuf_inst_align_if.slave        bus
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             inst_vld_q, inst_vld_d;
    logic [31:0]      inst_q, inst_d;
    logic             inst_32_q, inst_32_d;
    logic             acc_err_q, acc_err_d;

    logic [15:0]      hw [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] hw_pad;
    logic             unused_hw_pad;

    logic [PTR_W-1:0] h1_ptr;
    logic [15:0]      h0, h1;
    logic             h0_vld, h1_vld, h0_err, h1_err;
    logic             is32, take2, can_issue, load;

    // Unpack halfwords; bit 16 of each entry carries no meaning here.
    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_unpack
        assign hw[i]     = bus.entry_inst[17*i +: 16];
        assign hw_pad[i] = bus.entry_inst[17*i+16];
    end
    assign unused_hw_pad = ^hw_pad;

    assign h1_ptr    = rd_ptr_q + PTR_W'(1);
    assign h0        = hw[rd_ptr_q];
    assign h1        = hw[h1_ptr];
    assign h0_vld    = bus.entry_vld[rd_ptr_q];
    assign h1_vld    = bus.entry_vld[h1_ptr];
    assign h0_err    = bus.entry_acc_err[rd_ptr_q];
    assign h1_err    = bus.entry_acc_err[h1_ptr];

    // An access error on h0 is issued as a single halfword regardless of length bits.
    assign is32      = (h0[1:0] == 2'b11);
    assign take2     = is32 & ~h0_err;
    assign can_issue = h0_vld & (h0_err | ~is32 | h1_vld);
    assign load      = can_issue & (~inst_vld_q | bus.dec_ready) & ~bus.ibuf_flush;

    // Retire strobes track the load; forced low while reset is asserted.
    always_comb begin
        bus.entry_retire0_en = '0;
        bus.entry_retire1_en = '0;
        if (load && cpurst_b) begin
            bus.entry_retire0_en = ENTRY_NUM'(1) << rd_ptr_q;
            if (take2) begin
                bus.entry_retire1_en = ENTRY_NUM'(1) << h1_ptr;
            end
        end
    end

    // Next state: flush, then load, then drain on acceptance.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        inst_vld_d = inst_vld_q;
        inst_d     = inst_q;
        inst_32_d  = inst_32_q;
        acc_err_d  = acc_err_q;
        if (bus.ibuf_flush) begin
            rd_ptr_d   = '0;
            inst_vld_d = 1'b0;
        end else if (load) begin
            inst_vld_d = 1'b1;
            inst_32_d  = take2;
            acc_err_d  = h0_err | (take2 & h1_err);
            inst_d     = take2 ? {h1, h0} : {16'h0000, h0};
            rd_ptr_d   = rd_ptr_q + (take2 ? PTR_W'(2) : PTR_W'(1));
        end else if (inst_vld_q && bus.dec_ready) begin
            inst_vld_d = 1'b0;
        end
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_ptr_q   <= '0;
            inst_vld_q <= 1'b0;
            inst_q     <= '0;
            inst_32_q  <= 1'b0;
            acc_err_q  <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            inst_vld_q <= inst_vld_d;
            inst_q     <= inst_d;
            inst_32_q  <= inst_32_d;
            acc_err_q  <= acc_err_d;
        end
    end

    assign bus.align_inst_vld = inst_vld_q;
    assign bus.align_inst     = inst_q;
    assign bus.align_inst_32  = inst_32_q;
    assign bus.align_acc_err  = acc_err_q;

`ifdef CR_IFU_ALIGN_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the decoder holds off a valid instruction.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (inst_vld_q && !bus.dec_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.align_stall_cnt = stall_cnt_q;
`endif

endmodule
